// File: rtl/rf_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM states,
// flag bit positions and opcode classification helpers.
package rf_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_MOVI = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_L = 2;
  localparam int unsigned FLAG_F = 1;
  localparam int unsigned FLAG_Z = 0;

  function automatic logic op_writes(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOVI);
  endfunction

  function automatic logic op_sets_flags(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_CMP;
  endfunction

endpackage

// File: rtl/rf_op_sequencer_if.sv
// Instruction handshake, register-file port and status bundle of the sequencer.
interface rf_op_sequencer_if;
  logic        InstrValid;
  logic [15:0] Instr;
  logic        InstrReady;
  logic [3:0]  RdestRegLoc;
  logic [3:0]  RsrcRegLoc;
  logic [15:0] RdestOut;
  logic [15:0] RsrcOut;
  logic        WrEn;
  logic [15:0] WrData;
  logic [3:0]  Flags;
  logic        Done;
  logic        Illegal;

  // master: the sequencer, which owns the register file's address/write side
  modport master (
    input  InstrValid, Instr, RdestOut, RsrcOut,
    output InstrReady, RdestRegLoc, RsrcRegLoc, WrEn, WrData, Flags, Done, Illegal
  );

  modport slave (
    output InstrValid, Instr, RdestOut, RsrcOut,
    input  InstrReady, RdestRegLoc, RsrcRegLoc, WrEn, WrData, Flags, Done, Illegal
  );
endinterface

// File: rtl/rf_alu.sv
// Combinational ALU: 16-bit result plus candidate {C, L, F, Z} flags.
module rf_alu
  import rf_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [7:0]  imm,
  output logic [15:0] result,
  output logic [3:0]  flags_next
);

  logic [16:0] sum;
  logic [16:0] diff;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    result     = '0;
    flags_next = '0;
    case (opcode)
      OP_ADD: begin
        result             = sum[15:0];
        flags_next[FLAG_C] = sum[16];
        flags_next[FLAG_F] = (A[15] == B[15]) && (sum[15] != A[15]);
      end
      OP_SUB, OP_CMP: begin
        // bit 16 of the widened difference is the unsigned borrow (A < B)
        result             = diff[15:0];
        flags_next[FLAG_C] = diff[16];
        flags_next[FLAG_L] = diff[16];
        flags_next[FLAG_F] = (A[15] != B[15]) && (diff[15] != A[15]);
      end
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_MOV:  result = B;
      OP_MOVI: result = {8'h00, imm};
      default: result = '0;
    endcase
    flags_next[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Four-phase sequencer (IDLE/READ/EXEC/WB) executing one register-register
// instruction at a time against the 16 x 16-bit register file.
module rf_op_sequencer
  import rf_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  rf_op_sequencer_if.master   bus
);

  state_t      state, state_nx;
  logic        ready_q;
  logic [15:0] instr_q;
  logic [15:0] opa_q, opb_q;
  logic [15:0] result_q;
  logic [3:0]  flags_q;

  logic [3:0]  opcode;
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic        accept;

  assign opcode = instr_q[15:12];
  assign accept = (state == IDLE) && ready_q && bus.InstrValid;

  rf_alu u_alu (
    .opcode     (opcode),
    .A          (opa_q),
    .B          (opb_q),
    .imm        (instr_q[7:0]),
    .result     (alu_result),
    .flags_next (alu_flags)
  );

  // Ready is registered from the next state so it stays low during reset
  // and only rises on the first edge after release.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= (state_nx == IDLE);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      instr_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) instr_q <= bus.Instr;
        READ: begin
          opa_q <= bus.RdestOut;
          opb_q <= bus.RsrcOut;
        end
        EXEC: begin
          result_q <= alu_result;
          if (op_sets_flags(opcode)) flags_q <= alu_flags;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    bus.WrEn    = 1'b0;
    bus.Done    = 1'b0;
    bus.Illegal = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = READ;
      READ: state_nx = EXEC;
      EXEC: state_nx = WB;
      WB: begin
        bus.WrEn    = op_writes(opcode);
        bus.Done    = 1'b1;
        bus.Illegal = op_illegal(opcode);
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.InstrReady  = ready_q;
  assign bus.RdestRegLoc = instr_q[11:8];
  assign bus.RsrcRegLoc  = instr_q[3:0];
  assign bus.WrData      = result_q;
  assign bus.Flags       = flags_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Self-checking bench for rf_op_sequencer with a register-file model and an
// instruction-level reference model.
module tb_rf_op_sequencer;

  logic Clk;
  logic Rst;
  rf_op_sequencer_if bus ();

  rf_op_sequencer dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file seen by the DUT, with a bench-side preload port.
  logic [15:0] rf [16];
  logic        pk_en;
  logic [3:0]  pk_addr;
  logic [15:0] pk_data;

  always @(posedge Clk) begin
    if (pk_en) rf[pk_addr] <= pk_data;
    else if (bus.WrEn) rf[bus.RdestRegLoc] <= bus.WrData;
  end

  assign bus.RdestOut = rf[bus.RdestRegLoc];
  assign bus.RsrcOut  = rf[bus.RsrcRegLoc];

  int done_cnt = 0;
  always @(posedge Clk) if (bus.Done === 1'b1) done_cnt++;

  // Reference model: architectural register contents and flags.
  logic [15:0] model_rf [16];
  logic [3:0]  model_flags;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Executes one instruction architecturally; returns expected writeback data,
  // write enable and illegal indication, and updates model state.
  task automatic model_exec(input logic [15:0] ins, output logic [15:0] res,
                            output logic we, output logic ill);
    int unsigned a, b, r, op;
    int sa, sb, sr;
    logic c, f;
    op = ins[15:12];
    a  = model_rf[ins[11:8]];
    b  = model_rf[ins[3:0]];
    sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
    sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
    r = 0; we = 1'b0; ill = 1'b0;
    case (op)
      0: ;
      1: begin
        r  = (a + b) % 65536;
        c  = (a + b) > 65535;
        sr = sa + sb;
        f  = (sr > 32767) || (sr < -32768);
        model_flags = {c, 1'b0, f, r == 0};
        we = 1'b1;
      end
      2, 8: begin
        r  = (a + 65536 - b) % 65536;
        c  = a < b;
        sr = sa - sb;
        f  = (sr > 32767) || (sr < -32768);
        model_flags = {c, c, f, r == 0};
        we = (op == 2);
      end
      3: begin r = a & b; we = 1'b1; end
      4: begin r = a | b; we = 1'b1; end
      5: begin r = a ^ b; we = 1'b1; end
      6: begin r = b;     we = 1'b1; end
      7: begin r = ins[7:0]; we = 1'b1; end
      default: ill = 1'b1;
    endcase
    res = r[15:0];
    if (we) model_rf[ins[11:8]] = res;
  endtask

  // Call just after a falling edge with the DUT idle or about to become idle.
  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    @(posedge Clk); #1;
    pk_en = 1'b0;
    model_rf[a] = d;
    @(negedge Clk);
  endtask

  task automatic run_instr(input logic [15:0] ins, input string tag);
    logic [15:0] res;
    logic we, ill;
    int n;
    n = 0;
    while (bus.InstrReady !== 1'b1 && n < 8) begin @(negedge Clk); n++; end
    chk({tag, " ready_before"}, bus.InstrReady, 1);
    bus.Instr = ins; bus.InstrValid = 1'b1;
    model_exec(ins, res, we, ill);
    @(posedge Clk); #1;
    bus.InstrValid = 1'b0; bus.Instr = 16'($urandom);
    @(negedge Clk);
    chk({tag, " c1_ready"}, bus.InstrReady, 0);
    chk({tag, " c1_rdloc"}, bus.RdestRegLoc, ins[11:8]);
    chk({tag, " c1_rsloc"}, bus.RsrcRegLoc, ins[3:0]);
    chk({tag, " c1_done"}, bus.Done, 0);
    @(negedge Clk);
    chk({tag, " c2_ready"}, bus.InstrReady, 0);
    chk({tag, " c2_wren"}, bus.WrEn, 0);
    @(negedge Clk);
    chk({tag, " c3_wren"}, bus.WrEn, we);
    chk({tag, " c3_done"}, bus.Done, 1);
    chk({tag, " c3_illegal"}, bus.Illegal, ill);
    chk({tag, " c3_flags"}, bus.Flags, model_flags);
    chk({tag, " c3_rdloc"}, bus.RdestRegLoc, ins[11:8]);
    if (we) chk({tag, " c3_wrdata"}, bus.WrData, res);
    @(negedge Clk);
    chk({tag, " c4_ready"}, bus.InstrReady, 1);
    chk({tag, " c4_done"}, bus.Done, 0);
    chk({tag, " c4_wren"}, bus.WrEn, 0);
    chk({tag, " c4_rdloc_hold"}, bus.RdestRegLoc, ins[11:8]);
    chk({tag, " c4_regfile"}, rf[ins[11:8]], model_rf[ins[11:8]]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] list [3];
    logic [15:0] res;
    logic we, ill;
    logic [3:0] flags_saved;
    logic rdy;
    int acc [3];
    int k, d0, last;

    Rst = 1'b0; bus.InstrValid = 1'b0; bus.Instr = '0; pk_en = 1'b0;
    pk_addr = '0; pk_data = '0; model_flags = '0;
    @(negedge Clk);
    for (int i = 0; i < 16; i++) poke(4'(i), 16'($urandom));

    // Reset state
    chk("rst_ready", bus.InstrReady, 0);
    chk("rst_wren", bus.WrEn, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_illegal", bus.Illegal, 0);
    chk("rst_flags", bus.Flags, 0);
    chk("rst_wrdata", bus.WrData, 0);
    chk("rst_rdloc", bus.RdestRegLoc, 0);
    chk("rst_rsloc", bus.RsrcRegLoc, 0);
    Rst = 1'b1;
    #1 chk("rst_release_ready_low", bus.InstrReady, 0);
    @(posedge Clk); #1;
    chk("rst_first_edge_ready", bus.InstrReady, 1);
    @(negedge Clk);

    // ADD signed overflow
    poke(4'd1, 16'h7FFF); poke(4'd2, 16'h0001);
    d0 = done_cnt;
    run_instr(16'h1102, "add");
    chk("add_r1", rf[1], 16'h8000);
    chk("add_flags", bus.Flags, 4'b0010);
    chk("add_done_once", done_cnt - d0, 1);

    // SUB to zero, then CMP with borrow
    poke(4'd3, 16'h0005); poke(4'd4, 16'h0005);
    run_instr(16'h2304, "sub");
    chk("sub_r3", rf[3], 16'h0000);
    chk("sub_flags", bus.Flags, 4'b0001);
    run_instr(16'h8304, "cmp");
    chk("cmp_flags", bus.Flags, 4'b1100);
    chk("cmp_r3_kept", rf[3], 16'h0000);

    // MOVI / MOV leave flags alone
    flags_saved = bus.Flags;
    run_instr(16'h7FA5, "movi");
    run_instr(16'h600F, "mov");
    chk("mov_r0", rf[0], 16'h00A5);
    chk("mov_flags_held", bus.Flags, flags_saved);

    // Illegal opcode
    run_instr(16'hC123, "illegal");
    chk("illegal_flags_held", bus.Flags, flags_saved);

    // Back-to-back with InstrValid held high
    list[0] = 16'h1562; list[1] = 16'h2756; list[2] = 16'h5876;
    d0 = done_cnt; k = 0; last = -10;
    bus.Instr = list[0]; bus.InstrValid = 1'b1;
    model_exec(list[0], res, we, ill);
    for (int c = 0; c < 16; c++) begin
      rdy = bus.InstrReady;
      if (k > 0 && c > last && c <= last + 3) chk("b2b_ready_low", rdy, 0);
      @(posedge Clk); #1;
      if (rdy && bus.InstrValid) begin
        acc[k] = c; last = c; k++;
        if (k < 3) begin
          bus.Instr = list[k];
          model_exec(list[k], res, we, ill);
        end else begin
          bus.InstrValid = 1'b0;
        end
      end
      @(negedge Clk);
    end
    chk("b2b_accepts", k, 3);
    chk("b2b_gap01", acc[1] - acc[0], 4);
    chk("b2b_gap12", acc[2] - acc[1], 4);
    chk("b2b_dones", done_cnt - d0, 3);
    chk("b2b_r5", rf[5], model_rf[5]);
    chk("b2b_r7", rf[7], model_rf[7]);
    chk("b2b_r8", rf[8], model_rf[8]);
    chk("b2b_flags", bus.Flags, model_flags);

    // Random instructions, including edge values and Rdest == Rsrc
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) poke(4'($urandom), (i % 12 == 0) ? 16'hFFFF : 16'h8000);
      run_instr({4'($urandom_range(0, 15)), 4'($urandom), 8'($urandom)}, "rand");
    end

    // Reset during EXEC of an ADD
    poke(4'd9, 16'h1234); poke(4'd10, 16'h1111);
    d0 = done_cnt;
    bus.Instr = 16'h190A; bus.InstrValid = 1'b1;
    @(posedge Clk); #1;
    bus.InstrValid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("mid_rst_wren", bus.WrEn, 0);
    chk("mid_rst_done", bus.Done, 0);
    chk("mid_rst_ready", bus.InstrReady, 0);
    chk("mid_rst_flags", bus.Flags, 0);
    chk("mid_rst_wrdata", bus.WrData, 0);
    chk("mid_rst_rdloc", bus.RdestRegLoc, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk("mid_rst_hold_wren", bus.WrEn, 0);
    end
    model_flags = '0;
    Rst = 1'b1;
    @(negedge Clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_no_write", rf[9], 16'h1234);
    run_instr(16'h190A, "post_rst_add");
    chk("post_rst_r9", rf[9], 16'h2345);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
